sec_timer_sched: RTL and testbench
==================================

Name: sec_timer_sched

Overview:
- Shared one-second time base plus scheduler for four independent countdown channels.
- Owns the prescaler and issues a registered 1-cycle `tick` enable; it does not generate a divided clock.
- Arbitrates one command interface among the channels and reports per-channel busy and done status.
- Sits between the board clock and user logic such as stopwatches and alarms, so those blocks never instantiate their own dividers.

Parameters:
- DIV, 50000000, clk cycles per tick (1 s at 50 MHz); legal range 2..2^26.
- CW, 26, prescaler counter width; must satisfy 2^CW >= DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_ch  in  2  target channel 0..3
- cmd_op  in  2  00 START, 01 STOP, 10 PAUSE, 11 RESUME
- cmd_sec  in  8  START load value in seconds
- rd_ch  in  2  readback channel select
- rd_sec  out  8  remaining seconds of rd_ch (combinational mux of registers)
- busy  out  4  channel in RUN or PAUSE
- done  out  4  1-cycle pulse on countdown expiry
- tick  out  1  1-cycle pulse at each second boundary while the prescaler runs

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - all channels IDLE, remaining=0, prescaler=0.
  - tick=0, done=0, busy=0.
- Prescaler:
  - Runs only while some channel is in RUN.
  - When no channel is in RUN, it is held at 0.
  - When running, it counts 0..DIV-1 and wraps to 0.
  - tick is registered: it is 1 in the cycle after the count equals DIV-1.
  - First tick after a start from all-idle comes exactly DIV cycles after acceptance.
  - A channel started while others run sees its first tick at the next shared boundary (0..DIV cycles); this jitter is specified behaviour.
- cmd_ready = ~tick:
  - Commands stall during a tick cycle, so a command and a decrement never collide.
  - A command held valid through a tick is accepted on the following cycle.
- Command effects (registered; state, busy and rd_sec update the cycle after acceptance):
  - START, cmd_sec>0: remaining=cmd_sec, state RUN. Legal from any state; restarts a running or paused channel.
  - START, cmd_sec=0: channel stays/returns IDLE, remaining=0, done pulses the cycle after acceptance.
  - STOP: IDLE, remaining=0, no done pulse.
  - PAUSE: RUN becomes PAUSE. Ignored in IDLE and PAUSE.
  - RESUME: PAUSE becomes RUN. Ignored in IDLE and RUN.
- Channel state machine: IDLE, RUN, PAUSE.
  - On a tick cycle, every RUN channel with remaining>1 decrements by 1.
  - A RUN channel with remaining=1 goes to 0 and IDLE, and its done bit pulses the next cycle.
  - Several channels may expire on the same tick; their done bits pulse together.
  - PAUSE channels hold remaining; the prescaler keeps counting if any other channel is in RUN.
  - If pausing the last RUN channel leaves none running, the prescaler clears to 0. On resume, a full DIV cycles pass before the next tick.
- Arithmetic:
  - remaining is 8-bit unsigned and never decrements below 0.
  - Prescaler compare uses CW bits; no overflow is possible given the parameter rule.
- Reset mid-countdown: everything clears next edge, no done pulse is emitted, and a pending tick is dropped.
- Latency summary:
  - command to state: 1 cycle.
  - DIV-boundary count to tick: 1 cycle.
  - tick to done: 1 cycle.

Test Plan (DIV=10 for simulation):
- Reset held 3 cycles with cmd_valid=1 → busy=0, done=0, tick=0, rd_sec=0 for all channels; after reset release, cmd_ready=1.
- START ch0 sec=3 from idle at cycle T → busy[0]=1 at T+1, ticks at T+10/T+20/T+30, rd_sec 3→2→1→0, done[0] pulse at T+31, busy[0]=0 at T+31.
- START ch1 sec=2 and ch2 sec=1 on consecutive cycles → ch2 done at first tick+1, ch1 done at second tick+1, with no extra ticks after both are idle.
- START ch0 sec=5, PAUSE after 2 ticks, wait 50 cycles, RESUME → rd_sec stays 3 while paused, no tick occurs while all are paused, 3 more ticks follow the resume, then done.
- cmd_valid asserted in a tick cycle → cmd_ready=0 that cycle, command takes effect one cycle later, decrement and command both applied correctly.
- START ch3 sec=0 → done[3] 1-cycle pulse next cycle, busy[3] never set. STOP ch0 mid-run → busy[0]=0, no done. rst mid-run → no done, all cleared.

Source files
------------

// File: rtl/sec_timer_sched.sv
// Shared one-second time base and scheduler for four countdown channels.
// A single prescaler produces a registered 1-cycle tick enable (no divided clock).
// One command port is shared by all channels. Each channel reports busy and a done pulse.
module sec_timer_sched #(
  parameter int unsigned DIV = 50000000,
  parameter int unsigned CW  = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_ch,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_sec,
  input  logic [1:0] rd_ch,
  output logic [7:0] rd_sec,
  output logic [3:0] busy,
  output logic [3:0] done,
  output logic       tick
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } ch_state_e;

  localparam logic [1:0] OpStart  = 2'b00;
  localparam logic [1:0] OpStop   = 2'b01;
  localparam logic [1:0] OpPause  = 2'b10;
  localparam logic [1:0] OpResume = 2'b11;

  localparam logic [CW-1:0] PrescLast = CW'(DIV - 1);

  ch_state_e     state_q [4];
  ch_state_e     state_d [4];
  logic [7:0]    rem_q   [4];
  logic [7:0]    rem_d   [4];
  logic [CW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [3:0]    done_q, done_d;
  logic [3:0]    run_d;
  logic          any_run_d;
  logic          cmd_fire;

  // Commands stall on tick cycles so a command never races a decrement.
  assign cmd_ready = ~tick_q;
  assign cmd_fire  = cmd_valid & ~tick_q;

  // Per-channel next state: tick-driven countdown, otherwise the accepted command.
  always_comb begin
    done_d = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      if (tick_q) begin
        if (state_q[i] == StRun) begin
          if (rem_q[i] > 8'd1) begin
            rem_d[i] = rem_q[i] - 8'd1;
          end else begin
            // Expiry; rem of 0 in RUN is unreachable but also retires the channel.
            rem_d[i]   = 8'd0;
            state_d[i] = StIdle;
            done_d[i]  = 1'b1;
          end
        end
      end else if (cmd_fire && (cmd_ch == 2'(i))) begin
        unique case (cmd_op)
          OpStart: begin
            if (cmd_sec != 8'd0) begin
              rem_d[i]   = cmd_sec;
              state_d[i] = StRun;
            end else begin
              // A zero-length countdown expires immediately.
              rem_d[i]   = 8'd0;
              state_d[i] = StIdle;
              done_d[i]  = 1'b1;
            end
          end
          OpStop: begin
            rem_d[i]   = 8'd0;
            state_d[i] = StIdle;
          end
          OpPause: begin
            if (state_q[i] == StRun) state_d[i] = StPause;
          end
          OpResume: begin
            if (state_q[i] == StPause) state_d[i] = StRun;
          end
          default: ;
        endcase
      end
    end
  end

  // Which channels will be running next cycle; drives the prescaler enable.
  always_comb begin
    run_d = '0;
    for (int i = 0; i < 4; i++) begin
      run_d[i] = (state_d[i] == StRun);
    end
    any_run_d = |run_d;
  end

  // Prescaler next state. Using the next-cycle run set makes the first tick land
  // exactly DIV cycles after a start from idle, and clears the count on the cycle
  // the last running channel leaves RUN.
  always_comb begin
    presc_d = '0;
    tick_d  = 1'b0;
    if (any_run_d) begin
      if (presc_q == PrescLast) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + CW'(1);
      end
    end
  end

  // State registers with synchronous reset; reset drops any pending tick and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= StIdle;
        rem_q[i]   <= 8'd0;
      end
      presc_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
      presc_q <= presc_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  // Status outputs decoded from registered state.
  always_comb begin
    busy = '0;
    for (int i = 0; i < 4; i++) begin
      busy[i] = (state_q[i] != StIdle);
    end
  end

  assign rd_sec = rem_q[rd_ch];
  assign done   = done_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_sec_timer_sched.sv
// Directed bench for sec_timer_sched with DIV=10. Expected tick and done events
// are queued when commands are driven and checked every cycle by a monitor.
module tb_sec_timer_sched;

  localparam int unsigned DIV = 10;
  localparam int unsigned CW  = 4;

  localparam logic [1:0] OpStart  = 2'b00;
  localparam logic [1:0] OpStop   = 2'b01;
  localparam logic [1:0] OpPause  = 2'b10;
  localparam logic [1:0] OpResume = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_ch = 2'd0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_sec = 8'd0;
  logic [1:0] rd_ch = 2'd0;
  logic [7:0] rd_sec;
  logic [3:0] busy;
  logic [3:0] done;
  logic       tick;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         c;
    logic [3:0] m;
  } done_ev_t;

  int       exp_tick[$];
  done_ev_t exp_done[$];

  logic       mon_exp_t;
  logic [3:0] mon_exp_m;

  sec_timer_sched #(
    .DIV(DIV),
    .CW (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ch   (cmd_ch),
    .cmd_op   (cmd_op),
    .cmd_sec  (cmd_sec),
    .rd_ch    (rd_ch),
    .rd_sec   (rd_sec),
    .busy     (busy),
    .done     (done),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_rd(input logic [1:0] ch, input logic [7:0] exp, input string tag);
    rd_ch = ch;
    #1;
    chk(tag, 32'(rd_sec), 32'(exp));
  endtask

  task automatic push_done(input int c, input logic [3:0] m);
    done_ev_t ev;
    ev.c = c;
    ev.m = m;
    exp_done.push_back(ev);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive a command; t is the cycle in which it is accepted.
  task automatic issue(input logic [1:0] ch, input logic [1:0] op, input logic [7:0] sec,
                       output int t);
    int guard;
    guard     = 0;
    cmd_ch    = ch;
    cmd_op    = op;
    cmd_sec   = sec;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    t = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Scoreboard monitor: tick and done must match the queued events every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp_t = (exp_tick.size() > 0) && (exp_tick[0] == cyc);
      if (mon_exp_t) void'(exp_tick.pop_front());
      chk("tick", 32'(tick), 32'(mon_exp_t));
      mon_exp_m = 4'b0000;
      if (exp_done.size() > 0 && exp_done[0].c == cyc) begin
        mon_exp_m = exp_done[0].m;
        void'(exp_done.pop_front());
      end
      chk("done", 32'(done), 32'(mon_exp_m));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int r;
    int t_exp;

    // Reset with a command pending.
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_ch    = 2'd0;
    cmd_op    = OpStart;
    cmd_sec   = 8'd7;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    for (int i = 0; i < 4; i++) chk_rd(2'(i), 8'd0, "rst_rd_sec");
    rst       = 1'b0;
    cmd_valid = 1'b0;
    mon_en    = 1'b1;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Single channel from idle: ticks at +10/+20/+30, done at +31.
    issue(2'd0, OpStart, 8'd3, t);
    exp_tick.push_back(t + 10);
    exp_tick.push_back(t + 20);
    exp_tick.push_back(t + 30);
    push_done(t + 31, 4'b0001);
    chk("t2_busy_start", 32'(busy), 32'b0001);
    chk_rd(2'd0, 8'd3, "t2_rd_start");
    wait_until(t + 11);
    chk_rd(2'd0, 8'd2, "t2_rd_after_tick1");
    wait_until(t + 21);
    chk_rd(2'd0, 8'd1, "t2_rd_after_tick2");
    wait_until(t + 31);
    chk_rd(2'd0, 8'd0, "t2_rd_end");
    chk("t2_busy_end", 32'(busy), 32'd0);

    // Two channels started back to back, expiring on different ticks.
    wait_until(t + 33);
    issue(2'd1, OpStart, 8'd2, t);
    issue(2'd2, OpStart, 8'd1, r);
    chk("t3_second_accept", r, t + 1);
    exp_tick.push_back(t + 10);
    exp_tick.push_back(t + 20);
    push_done(t + 11, 4'b0100);
    push_done(t + 21, 4'b0010);
    chk("t3_busy_both", 32'(busy), 32'b0110);
    wait_until(t + 11);
    chk("t3_busy_ch1_only", 32'(busy), 32'b0010);
    chk_rd(2'd1, 8'd1, "t3_rd_ch1");
    wait_until(t + 21);
    chk("t3_busy_none", 32'(busy), 32'd0);
    wait_until(t + 50);

    // Pause after two ticks, idle long, resume for three more.
    issue(2'd0, OpStart, 8'd5, t);
    exp_tick.push_back(t + 10);
    exp_tick.push_back(t + 20);
    wait_until(t + 25);
    issue(2'd0, OpPause, 8'd0, r);
    chk_rd(2'd0, 8'd3, "t4_rd_paused");
    chk("t4_busy_paused", 32'(busy), 32'b0001);
    wait_until(r + 51);
    chk_rd(2'd0, 8'd3, "t4_rd_still_paused");
    issue(2'd0, OpResume, 8'd0, r);
    exp_tick.push_back(r + 10);
    exp_tick.push_back(r + 20);
    exp_tick.push_back(r + 30);
    push_done(r + 31, 4'b0001);
    wait_until(r + 11);
    chk_rd(2'd0, 8'd2, "t4_rd_resume1");
    wait_until(r + 21);
    chk_rd(2'd0, 8'd1, "t4_rd_resume2");
    wait_until(r + 31);
    chk_rd(2'd0, 8'd0, "t4_rd_end");
    chk("t4_busy_end", 32'(busy), 32'd0);

    // Command presented in a tick cycle: stalled one cycle, both effects land.
    wait_until(r + 33);
    issue(2'd0, OpStart, 8'd3, t);
    exp_tick.push_back(t + 10);
    exp_tick.push_back(t + 20);
    exp_tick.push_back(t + 30);
    exp_tick.push_back(t + 40);
    exp_tick.push_back(t + 50);
    push_done(t + 31, 4'b0001);
    push_done(t + 51, 4'b0010);
    wait_until(t + 10);
    chk("t5_ready_in_tick", 32'(cmd_ready), 32'd0);
    issue(2'd1, OpStart, 8'd4, r);
    chk("t5_accept_cycle", r, t + 11);
    chk_rd(2'd0, 8'd2, "t5_rd_ch0");
    chk_rd(2'd1, 8'd4, "t5_rd_ch1");
    chk("t5_busy_both", 32'(busy), 32'b0011);
    wait_until(t + 31);
    chk_rd(2'd1, 8'd2, "t5_rd_ch1_mid");
    chk("t5_busy_ch1", 32'(busy), 32'b0010);
    wait_until(t + 51);
    chk("t5_busy_end", 32'(busy), 32'd0);

    // Zero-second start: immediate done, never busy.
    wait_until(t + 53);
    t_exp = cyc;
    push_done(t_exp + 1, 4'b1000);
    issue(2'd3, OpStart, 8'd0, t);
    chk("t6_accept", t, t_exp);
    chk("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t6_busy_after", 32'(busy), 32'd0);

    // STOP mid-run: cleared, no done.
    issue(2'd0, OpStart, 8'd5, t);
    exp_tick.push_back(t + 10);
    wait_until(t + 15);
    issue(2'd0, OpStop, 8'd0, r);
    chk("t7_busy_stopped", 32'(busy), 32'd0);
    chk_rd(2'd0, 8'd0, "t7_rd_stopped");
    wait_until(t + 35);

    // Reset with a tick pending: tick dropped, no done, all cleared.
    issue(2'd0, OpStart, 8'd1, t);
    issue(2'd2, OpStart, 8'd3, r);
    wait_until(t + 9);
    rst = 1'b1;
    @(negedge clk);
    chk("t8_busy_rst", 32'(busy), 32'd0);
    chk("t8_tick_rst", 32'(tick), 32'd0);
    for (int i = 0; i < 4; i++) chk_rd(2'(i), 8'd0, "t8_rd_rst");
    rst = 1'b0;
    wait_until(t + 40);
    chk("t8_busy_after", 32'(busy), 32'd0);

    chk("tick_queue_drained", exp_tick.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
